ball_ctrl_sequencer: RTL and testbench
======================================

Name: ball_ctrl_sequencer

Overview:
- Sequences the LQR plate-angle update for both axes (X, Y) on each sample tick.
- Time-shares one pipelined signed multiplier across six gain products: K_POS·actual, K_VEL·delta, K_REF·desired, per axis.
- Accumulates the products, scales and offsets the sum, then emits two registered servo angles with a one-cycle valid strobe.
- Sits between the position-sensing front end and the servo PWM drivers. Replaces three parallel multipliers per axis.

Parameters:
- K_POS, 326, signed 13-bit position gain.
- K_VEL, 326, signed 13-bit velocity gain (per-tick delta).
- K_REF, 326, signed 13-bit reference gain.
- SHIFT, 10, arithmetic right shift applied to each axis accumulator.
- ANGLE_OFFSET, 85, signed offset added after the shift (level-plate angle).
- MULT_LAT, 2, multiplier pipeline depth in cycles (>=1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  single-cycle request to start an update.
- desired_x, desired_y  in  13  signed target positions.
- actual_x, actual_y  in  13  signed measured positions.
- busy  out  1  high from the accepted tick until angle_valid.
- angle_x, angle_y  out  11  signed servo angles.
- angle_valid  out  1  one-cycle pulse; angles updated in the same cycle.
- overrun  out  1  sticky; a tick arrived while busy.

Behaviour:
- Reset values (async): busy=0, angle_valid=0, overrun=0, angle_x=angle_y=ANGLE_OFFSET (saturated to 11 bits), prev_x=prev_y=0, primed=0, FSM=IDLE.
- States:
  - IDLE -> ISSUE on sample_tick.
  - ISSUE: 6 cycles, index 0..5 -> DRAIN.
  - DRAIN: MULT_LAT cycles -> DONE.
  - DONE: 1 cycle -> IDLE.
- Tick accepted in IDLE at edge T:
  - Latch all four positions.
  - delta_a = actual_a - prev_a as a 14-bit signed value, forced to 0 when primed=0.
  - prev_a <= actual_a; primed <= 1; busy <= 1.
- Issue order, one operand pair per cycle at edges T+1..T+6: X·pos, X·vel, X·ref, Y·pos, Y·vel, Y·ref. A 1-bit axis tag travels alongside through the multiplier.
- Products are 27-bit signed and are added into 30-bit per-axis accumulators as they emerge. Both accumulators clear at tick acceptance.
- At edge T+7+MULT_LAT (default T+9):
  - angle_a <= fit11((acc_a >>> SHIFT) + ANGLE_OFFSET).
  - angle_valid high for that cycle only; busy low from that cycle.
  - A new tick is accepted in the same cycle busy falls.
- sample_tick while busy: ignored, overrun <= 1. overrun clears only on reset.
- Inputs may change while busy; latched values are used.
- Reset mid-run: result discarded, no angle_valid, primed=0. The next tick gives delta=0.

Optional Feature:
- BALL_CTRL_SAT_EN defined: fit11 saturates to [-1024, 1023].
- Not defined: fit11 keeps the low 11 bits (two's-complement wrap).

Decomposition:
- Package ball_ctrl_pkg:
  - POS_W=13, VEL_W=14, ANG_W=11, PROD_W=27, ACC_W=30, NUM_PRODUCTS=6.
  - FSM state enum {IDLE, ISSUE, DRAIN, DONE}.
  - Issue-index encoding.
- One sub-module, seq_mult_pipe: signed 14x13 multiplier with MULT_LAT register stages, plus valid and tag pass-through. Sequencer, accumulators and output stage stay in the top.

Test Plan:
- First tick after reset, actual_x=100, others 0 -> delta forced to 0; acc_x=32600; angle_x=116, angle_y=85; angle_valid exactly at T+9.
- Next tick, actual_x=200, desired_x=0 -> delta=100; 65200+32600=97800, >>>10 gives 95; angle_x=180.
- First tick with actual_y=-100 -> -32600 >>>10 gives -32; angle_y=53 (checks floor on negative values).
- actual_x=desired_x=4095, first tick -> 2607+85=2692; with BALL_CTRL_SAT_EN angle_x=1023; without, angle_x=644.
- Second tick at T+4 while busy -> overrun=1; exactly one angle_valid pulse; results equal those of the first tick alone.
- reset pulsed at T+4 -> busy=0 immediately; no valid pulse; angles=85. Following tick with actual_x=100 -> angle_x=116 (delta 0 again).

Source files
------------

// File: rtl/ball_ctrl_pkg.sv
// ball_ctrl_pkg: shared widths, FSM/issue encodings and the fit11 angle narrowing
// used by the ball-balancing plate-angle sequencer.
// Build option: BALL_CTRL_SAT_EN -> fit11 saturates to the 11-bit range;
// undefined (default) -> fit11 keeps the low 11 bits (two's-complement wrap).
package ball_ctrl_pkg;

    localparam int POS_W        = 13;
    localparam int VEL_W        = 14;
    localparam int ANG_W        = 11;
    localparam int PROD_W       = 27;
    localparam int ACC_W        = 30;
    localparam int NUM_PRODUCTS = 6;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Issue slots, one gain product per cycle
    localparam logic [2:0] IDX_X_POS = 3'd0;
    localparam logic [2:0] IDX_X_VEL = 3'd1;
    localparam logic [2:0] IDX_X_REF = 3'd2;
    localparam logic [2:0] IDX_Y_POS = 3'd3;
    localparam logic [2:0] IDX_Y_VEL = 3'd4;
    localparam logic [2:0] IDX_Y_REF = 3'd5;
    localparam logic [2:0] IDX_LAST  = 3'(NUM_PRODUCTS - 1);

    // Axis tag carried through the multiplier
    localparam logic TAG_X = 1'b0;
    localparam logic TAG_Y = 1'b1;

    // Narrow a shifted/offset accumulator value to a servo angle.
    function automatic logic signed [ANG_W-1:0] fit11(input logic signed [ACC_W:0] v);
`ifdef BALL_CTRL_SAT_EN
        if (v > (ACC_W+1)'(1023)) begin
            return {1'b0, {(ANG_W-1){1'b1}}};
        end else if (v < (ACC_W+1)'(-1024)) begin
            return {1'b1, {(ANG_W-1){1'b0}}};
        end else begin
            return v[ANG_W-1:0];
        end
`else
        return v[ANG_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/ball_ctrl_sequencer_mult.sv
// seq_mult_pipe: signed 14x13 multiplier with MULT_LAT register stages.
// A valid bit and a one-bit axis tag travel alongside each product.
module seq_mult_pipe
    import ball_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_tag,
    input  logic signed [VEL_W-1:0]  in_a,
    input  logic signed [POS_W-1:0]  in_b,
    output logic                     out_valid,
    output logic                     out_tag,
    output logic signed [PROD_W-1:0] out_prod
);

    logic signed [PROD_W-1:0] prod_d [MULT_LAT];
    logic signed [PROD_W-1:0] prod_q [MULT_LAT];
    logic [MULT_LAT-1:0]      vld_d, vld_q;
    logic [MULT_LAT-1:0]      tag_d, tag_q;

    // Stage 0 takes the fresh product; later stages shift the pipeline along.
    always_comb begin
        prod_d    = '{default: '0};
        vld_d     = '0;
        tag_d     = '0;
        prod_d[0] = PROD_W'(in_a) * PROD_W'(in_b);
        vld_d[0]  = in_valid;
        tag_d[0]  = in_tag;
        for (int unsigned i = 1; i < MULT_LAT; i++) begin
            prod_d[i] = prod_q[i-1];
            vld_d[i]  = vld_q[i-1];
            tag_d[i]  = tag_q[i-1];
        end
    end

    // Pipeline registers; reset flushes in-flight products.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod_q <= '{default: '0};
            vld_q  <= '0;
            tag_q  <= '0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
            tag_q  <= tag_d;
        end
    end

    assign out_valid = vld_q[MULT_LAT-1];
    assign out_tag   = tag_q[MULT_LAT-1];
    assign out_prod  = prod_q[MULT_LAT-1];

endmodule

// File: rtl/ball_ctrl_sequencer.sv
// ball_ctrl_sequencer: per-sample LQR plate-angle update for X and Y, sharing
// one pipelined multiplier over six gain products, then shift, offset and
// narrow each axis sum into a registered servo angle.
// Build option: BALL_CTRL_SAT_EN selects saturating angle narrowing.
module ball_ctrl_sequencer
    import ball_ctrl_pkg::*;
#(
    parameter logic signed [POS_W-1:0] K_POS        = 13'sd326,
    parameter logic signed [POS_W-1:0] K_VEL        = 13'sd326,
    parameter logic signed [POS_W-1:0] K_REF        = 13'sd326,
    parameter int                      SHIFT        = 10,
    parameter int                      ANGLE_OFFSET = 85,
    parameter int                      MULT_LAT     = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sample_tick,
    input  logic signed [POS_W-1:0] desired_x,
    input  logic signed [POS_W-1:0] desired_y,
    input  logic signed [POS_W-1:0] actual_x,
    input  logic signed [POS_W-1:0] actual_y,
    output logic                    busy,
    output logic signed [ANG_W-1:0] angle_x,
    output logic signed [ANG_W-1:0] angle_y,
    output logic                    angle_valid,
    output logic                    overrun
);

    localparam logic signed [ACC_W:0]   OFFSET_EXT  = (ACC_W+1)'(ANGLE_OFFSET);
    localparam logic signed [ANG_W-1:0] RESET_ANGLE = fit11(OFFSET_EXT);
    localparam logic [7:0]              DRAIN_LAST  = 8'(MULT_LAT - 1);

    logic [1:0]               state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    logic [7:0]               drain_q, drain_d;
    logic                     busy_q, busy_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;
    logic                     primed_q, primed_d;
    logic signed [POS_W-1:0]  prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic signed [POS_W-1:0]  act_x_q, act_x_d, act_y_q, act_y_d;
    logic signed [POS_W-1:0]  des_x_q, des_x_d, des_y_q, des_y_d;
    logic signed [VEL_W-1:0]  dlt_x_q, dlt_x_d, dlt_y_q, dlt_y_d;
    logic signed [VEL_W-1:0]  dlt_x_new, dlt_y_new;
    logic signed [ACC_W-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic signed [ACC_W:0]    ext_x, ext_y, sum_x, sum_y;
    logic signed [ANG_W-1:0]  angle_x_q, angle_x_d, angle_y_q, angle_y_d;

    logic                     mult_in_valid, mult_in_tag;
    logic signed [VEL_W-1:0]  mult_a;
    logic signed [POS_W-1:0]  mult_b;
    logic                     mult_out_valid, mult_out_tag;
    logic signed [PROD_W-1:0] mult_out_prod;

    // Velocity terms for a tick; zero until a previous sample exists.
    always_comb begin
        dlt_x_new = '0;
        dlt_y_new = '0;
        if (primed_q) begin
            dlt_x_new = VEL_W'(actual_x) - VEL_W'(prev_x_q);
            dlt_y_new = VEL_W'(actual_y) - VEL_W'(prev_y_q);
        end
    end

    // Sequencer: accept tick, walk the six issue slots, drain, publish angles.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        primed_d  = primed_q;
        prev_x_d  = prev_x_q;
        prev_y_d  = prev_y_q;
        act_x_d   = act_x_q;
        act_y_d   = act_y_q;
        des_x_d   = des_x_q;
        des_y_d   = des_y_q;
        dlt_x_d   = dlt_x_q;
        dlt_y_d   = dlt_y_q;
        angle_x_d = angle_x_q;
        angle_y_d = angle_y_q;
        overrun_d = overrun_q | (sample_tick & busy_q);
        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    state_d  = ST_ISSUE;
                    idx_d    = IDX_X_POS;
                    busy_d   = 1'b1;
                    primed_d = 1'b1;
                    prev_x_d = actual_x;
                    prev_y_d = actual_y;
                    act_x_d  = actual_x;
                    act_y_d  = actual_y;
                    des_x_d  = desired_x;
                    des_y_d  = desired_y;
                    dlt_x_d  = dlt_x_new;
                    dlt_y_d  = dlt_y_new;
                end
            end
            ST_ISSUE: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                valid_d   = 1'b1;
                angle_x_d = fit11(sum_x);
                angle_y_d = fit11(sum_y);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand selection for the shared multiplier during ISSUE.
    always_comb begin
        mult_in_valid = 1'b0;
        mult_in_tag   = TAG_X;
        mult_a        = '0;
        mult_b        = '0;
        if (state_q == ST_ISSUE) begin
            mult_in_valid = 1'b1;
            case (idx_q)
                IDX_X_POS: begin mult_a = VEL_W'(act_x_q); mult_b = K_POS; mult_in_tag = TAG_X; end
                IDX_X_VEL: begin mult_a = dlt_x_q;         mult_b = K_VEL; mult_in_tag = TAG_X; end
                IDX_X_REF: begin mult_a = VEL_W'(des_x_q); mult_b = K_REF; mult_in_tag = TAG_X; end
                IDX_Y_POS: begin mult_a = VEL_W'(act_y_q); mult_b = K_POS; mult_in_tag = TAG_Y; end
                IDX_Y_VEL: begin mult_a = dlt_y_q;         mult_b = K_VEL; mult_in_tag = TAG_Y; end
                IDX_Y_REF: begin mult_a = VEL_W'(des_y_q); mult_b = K_REF; mult_in_tag = TAG_Y; end
                default:   mult_in_valid = 1'b0;
            endcase
        end
    end

    // Per-axis accumulation of emerging products; cleared when a tick is taken.
    always_comb begin
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        if (mult_out_valid) begin
            if (mult_out_tag == TAG_X) begin
                acc_x_d = acc_x_q + ACC_W'(mult_out_prod);
            end else begin
                acc_y_d = acc_y_q + ACC_W'(mult_out_prod);
            end
        end
        if ((state_q == ST_IDLE) && sample_tick) begin
            acc_x_d = '0;
            acc_y_d = '0;
        end
    end

    // Floor-scale each accumulator and add the level-plate offset.
    always_comb begin
        ext_x = {acc_x_q[ACC_W-1], acc_x_q};
        ext_y = {acc_y_q[ACC_W-1], acc_y_q};
        sum_x = (ext_x >>> SHIFT) + OFFSET_EXT;
        sum_y = (ext_y >>> SHIFT) + OFFSET_EXT;
    end

    seq_mult_pipe #(
        .MULT_LAT(MULT_LAT)
    ) u_mult (
        .clock    (clock),
        .reset    (reset),
        .in_valid (mult_in_valid),
        .in_tag   (mult_in_tag),
        .in_a     (mult_a),
        .in_b     (mult_b),
        .out_valid(mult_out_valid),
        .out_tag  (mult_out_tag),
        .out_prod (mult_out_prod)
    );

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            primed_q  <= 1'b0;
            prev_x_q  <= '0;
            prev_y_q  <= '0;
            act_x_q   <= '0;
            act_y_q   <= '0;
            des_x_q   <= '0;
            des_y_q   <= '0;
            dlt_x_q   <= '0;
            dlt_y_q   <= '0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            angle_x_q <= RESET_ANGLE;
            angle_y_q <= RESET_ANGLE;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            primed_q  <= primed_d;
            prev_x_q  <= prev_x_d;
            prev_y_q  <= prev_y_d;
            act_x_q   <= act_x_d;
            act_y_q   <= act_y_d;
            des_x_q   <= des_x_d;
            des_y_q   <= des_y_d;
            dlt_x_q   <= dlt_x_d;
            dlt_y_q   <= dlt_y_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            angle_x_q <= angle_x_d;
            angle_y_q <= angle_y_d;
        end
    end

    assign busy        = busy_q;
    assign angle_valid = valid_q;
    assign overrun     = overrun_q;
    assign angle_x     = angle_x_q;
    assign angle_y     = angle_y_q;

endmodule

// File: tb/tb_ball_ctrl_sequencer.sv
// Scoreboard bench for ball_ctrl_sequencer: the driver queues the expected
// angles per accepted tick; a monitor pops and compares on every angle_valid.
module tb_ball_ctrl_sequencer;

`ifdef BALL_CTRL_SAT_EN
    localparam int BIG_X = 1023;
`else
    localparam int BIG_X = 644;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sample_tick = 1'b0;
    logic signed [12:0] desired_x = '0, desired_y = '0, actual_x = '0, actual_y = '0;
    logic busy, angle_valid, overrun;
    logic signed [10:0] angle_x, angle_y;

    ball_ctrl_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .sample_tick(sample_tick),
        .desired_x  (desired_x),
        .desired_y  (desired_y),
        .actual_x   (actual_x),
        .actual_y   (actual_y),
        .busy       (busy),
        .angle_x    (angle_x),
        .angle_y    (angle_y),
        .angle_valid(angle_valid),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int    ax;
        int    ay;
        int    t;
        string name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   valid_count = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (angle_valid === 1'b1) begin
            valid_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_angle_x"}, int'(angle_x), mon_e.ax);
                chk({mon_e.name, "_angle_y"}, int'(angle_y), mon_e.ay);
                chk({mon_e.name, "_latency"}, cyc - mon_e.t, 9);
                chk({mon_e.name, "_busy_low"}, int'(busy), 0);
            end
        end
    end

    // Called just after a negedge: present a tick accepted at the next edge.
    task automatic tick_now(input string name, input int ax, input int ay,
                            input int dx, input int dy, input int ex, input int ey);
        exp_t e;
        actual_x    = 13'(ax);
        actual_y    = 13'(ay);
        desired_x   = 13'(dx);
        desired_y   = 13'(dy);
        sample_tick = 1'b1;
        e.ax   = ex;
        e.ay   = ey;
        e.t    = cyc + 1;
        e.name = name;
        exp_q.push_back(e);
        @(negedge clock);
        sample_tick = 1'b0;
        chk({name, "_busy_high"}, int'(busy), 1);
    endtask

    task automatic issue(input string name, input int ax, input int ay,
                         input int dx, input int dy, input int ex, input int ey);
        @(negedge clock);
        tick_now(name, ax, ay, dx, dy, ex, ey);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(angle_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_angle_x", int'(angle_x), 85);
        chk("rst_angle_y", int'(angle_y), 85);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int vc;
        int n;
        #1;
        do_reset();

        // First tick: velocity forced to zero, 100*326 >>> 10 = 31 -> 116
        issue("first_tick", 100, 0, 0, 0, 116, 85);
        wait_idle("first_tick");

        // delta 100: 65200 + 32600 = 97800 >>> 10 = 95 -> 180
        issue("delta_tick", 200, 0, 0, 0, 180, 85);
        wait_idle("delta_tick");

        // Negative sum floors: -32600 >>> 10 = -32 -> 53
        @(negedge clock);
        do_reset();
        issue("neg_floor", 0, -100, 0, 0, 85, 53);
        wait_idle("neg_floor");

        // Out-of-range angle: 2692 saturates or wraps
        @(negedge clock);
        do_reset();
        issue("big", 4095, 0, 4095, 0, BIG_X, 85);
        wait_idle("big");
        chk("no_overrun_yet", int'(overrun), 0);

        // Tick while busy is ignored and flags overrun
        @(negedge clock);
        do_reset();
        issue("overrun_run", 100, 0, 0, 0, 116, 85);
        vc = valid_count;
        repeat (3) @(negedge clock);
        actual_x    = 13'sd500;
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        chk("overrun_set", int'(overrun), 1);
        wait_idle("overrun_run");
        chk("overrun_one_pulse", valid_count - vc, 1);
        chk("overrun_sticky", int'(overrun), 1);

        // Reset mid-run discards the result and unprimes the delta
        @(negedge clock);
        do_reset();
        @(negedge clock);
        actual_x    = 13'sd300;
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        vc = valid_count;
        repeat (3) @(negedge clock);
        do_reset();
        repeat (14) @(negedge clock);
        chk("abort_no_valid", valid_count - vc, 0);
        issue("after_abort", 100, 0, 0, 0, 116, 85);
        wait_idle("after_abort");

        // Negative delta on X (-100) and reference-only Y (50*326 >>> 10 = 15)
        issue("neg_delta", 0, 0, 0, 50, 53, 100);
        wait_idle("neg_delta");

        // Back-to-back: next tick offered in the cycle busy falls
        issue("b2b_first", 0, 0, 0, 50, 85, 100);
        n = 0;
        while (angle_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("b2b_valid_seen", int'(angle_valid), 1);
        tick_now("b2b_second", 100, 0, 0, 0, 148, 85);
        wait_idle("b2b_second");
        chk("b2b_no_overrun", int'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
